// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one WIDTH-bit bitwise logic unit among NREQ requesters. A round-robin
//   winner is picked in IDLE. Its opcode and operands are captured on the grant
//   edge. The result is computed in EXEC. It is then held in RESP until the
//   consumer accepts it.
//   Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 NOT (~a).
//   Optional macro LU_OPCHECK_EN: opcodes 6/7 return data 0 with rsp_err=1.
//   Without it, opcodes 6/7 behave as NOT and rsp_err is tied 0.
// Ports
//   clk, rst_n            clock, async active-low reset
//   req[NREQ]             request per requester, held until its gnt
//   op[3*NREQ]            opcode of requester i at [3i+:3]
//   a/b[WIDTH*NREQ]       operands of requester i at [WIDTH*i+:WIDTH]
//   gnt[NREQ]             one-hot 1-cycle pulse: operands of i captured
//   busy                  high in EXEC and RESP
//   rsp_valid/rsp_ready   result handshake
//   rsp_id/data/err       owner index, result, illegal-opcode flag
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   a,
  input  logic [WIDTH*NREQ-1:0]   b,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, id_q, id_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic              found;
  logic [IDW-1:0]    win, scan_idx;
  logic [IDW:0]      scan_sum;
  logic [WIDTH-1:0]  alu_res;

`ifdef LU_OPCHECK_EN
  logic alu_err, rsp_err_q, rsp_err_d;
`endif

  // Round-robin search starting at ptr and wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) scan_sum = scan_sum - (IDW+1)'(NREQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // The bitwise unit works only on the latched operands.
  always_comb begin
    alu_res = '0;
`ifdef LU_OPCHECK_EN
    alu_err = 1'b0;
`endif
    case (op_q)
      3'd0: alu_res = a_q & b_q;
      3'd1: alu_res = a_q | b_q;
      3'd2: alu_res = ~(a_q & b_q);
      3'd3: alu_res = ~(a_q | b_q);
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = ~a_q;
`ifdef LU_OPCHECK_EN
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
`else
      default: alu_res = ~a_q;
`endif
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)     state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef LU_OPCHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        gnt_d[win] = 1'b1;
        id_d       = win;
        ptr_d      = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        // Constant-index mux keeps the operand selection width-clean.
        for (int i = 0; i < NREQ; i++) begin
          if (win == IDW'(i)) begin
            op_d = op[3*i +: 3];
            a_d  = a[WIDTH*i +: WIDTH];
            b_d  = b[WIDTH*i +: WIDTH];
          end
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = alu_res;
`ifdef LU_OPCHECK_EN
        rsp_err_d   = alu_err;
`endif
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef LU_OPCHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef LU_OPCHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
`ifdef LU_OPCHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: directed cases with literal expectations,
// then randomized traffic. A transaction-level model predicts every cycle.
module tb_logic_unit_arbiter;
  localparam int NREQ = 4, WIDTH = 8, IDW = 2;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [3:0]       req = '0;
  logic [11:0]      op = '0;
  logic [31:0]      a = '0, b = '0;
  logic             rsp_ready = 1'b1;
  logic [3:0]       gnt;
  logic             busy, rsp_valid, rsp_err;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_data;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: phase 0 = waiting for requests, 1 = op granted, 2 = result offered.
  int         m_phase = 0, m_ptr = 0;
  logic [3:0] e_gnt = '0;
  logic       e_valid = 1'b0, e_err = 1'b0, r_err = 1'b0;
  logic [7:0] e_data = '0, r_data = '0;
  logic [1:0] e_id = '0, r_id = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_res(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] d, output logic e);
    e = 1'b0;
    case (o)
      3'd0: d = x & y;
      3'd1: d = x | y;
      3'd2: d = ~(x & y);
      3'd3: d = ~(x | y);
      3'd4: d = x ^ y;
      3'd5: d = ~x;
`ifdef LU_OPCHECK_EN
      default: begin d = 8'h00; e = 1'b1; end
`else
      default: d = ~x;
`endif
    endcase
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; e_gnt = '0; e_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int w;
    e_gnt = '0;
    case (m_phase)
      0: if (req != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        e_gnt[w] = 1'b1;
        ref_res(op[3*w +: 3], a[8*w +: 8], b[8*w +: 8], r_data, r_err);
        r_id = 2'(w);
        m_ptr = (w + 1) % NREQ;
        m_phase = 1;
      end
      1: begin
        e_valid = 1'b1; e_data = r_data; e_id = r_id; e_err = r_err;
        m_phase = 2;
      end
      default: if (rsp_ready) begin e_valid = 1'b0; m_phase = 0; end
    endcase
  endtask

  // One cycle: the edge, then compare every meaningful output against the model.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
    if (e_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_data", 32'(rsp_data), 32'(e_data));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_valid"}, 32'(rsp_valid), 0);
    chk({nm, "_id"}, 32'(rsp_id), 0);
    chk({nm, "_data"}, 32'(rsp_data), 0);
    chk({nm, "_err"}, 32'(rsp_err), 0);
  endtask

  initial begin
    logic [7:0] exp5 [6];
    exp5[0] = 8'h03; exp5[1] = 8'h3F; exp5[2] = 8'hFC;
    exp5[3] = 8'hC0; exp5[4] = 8'h3C; exp5[5] = 8'hF0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    step();

    // Single XOR op from requester 0
    req = 4'b0001; op[2:0] = 3'd4; a[7:0] = 8'hF0; b[7:0] = 8'h3C;
    step(); chk("single_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_data", 32'(rsp_data), 32'hCC);
    chk("single_id", 32'(rsp_id), 0);
    step();

    // Reset while a result is being offered
    req = 4'b0001; op[2:0] = 3'd0; a[7:0] = 8'hFF; b[7:0] = 8'h0F; rsp_ready = 1'b0;
    step(); req = '0;
    step();
    chk("pre_reset_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1 chk_zero("midop_reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();

    // Round robin with all requests held; ptr starts at 0 after reset
    req = 4'b1111; op = '0; a = 32'h11223344; b = 32'hF0F0F0F0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      if (k == 4) req = '0;
      step(); step();
    end

    // Backpressure: result must hold, no grants while the result waits
    req = 4'b1110; op = '0; op[5:3] = 3'd5; a[15:8] = 8'hA5; rsp_ready = 1'b0;
    step(); chk("bp_gnt", 32'(gnt), 32'h2);
    req = 4'b1100;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'h5A);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_nogrant", 32'(gnt), 0);
    end
    rsp_ready = 1'b1;
    step(); chk("bp_release", 32'(rsp_valid), 0);
    step(); chk("bp_next_gnt", 32'(gnt), 32'h4);
    req = '0;
    step(); step();

    // Every legal opcode
    a[7:0] = 8'h0F; b[7:0] = 8'h33;
    for (int o = 0; o < 6; o++) begin
      req = 4'b0001; op[2:0] = 3'(o);
      step(); req = '0;
      step(); chk("allops_data", 32'(rsp_data), 32'(exp5[o]));
      step();
    end

    // Illegal opcode 7
    req = 4'b0001; op[2:0] = 3'd7;
    step(); req = '0;
    step();
`ifdef LU_OPCHECK_EN
    chk("illegal_data", 32'(rsp_data), 32'h00);
    chk("illegal_err", 32'(rsp_err), 1);
`else
    chk("illegal_data", 32'(rsp_data), 32'hF0);
    chk("illegal_err", 32'(rsp_err), 0);
`endif
    step();

    // Randomized traffic: requests held until granted, random backpressure
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (e_gnt[i]) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          op[3*i +: 3] = 3'($urandom_range(0, 7));
          a[8*i +: 8] = 8'($urandom);
          b[8*i +: 8] = 8'($urandom);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    req = '0; rsp_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
